// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and defaults for the serial byte loader
package loader_pkg;

    localparam int DATA_W_DEF       = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } loader_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    // next values: shift the asynchronous input through the chain
    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    // chain registers; reset to the line idle level so no false edge appears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= RST_VAL;
            ff2_q <= RST_VAL;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/serial_byte_loader.sv
// rtl/serial_byte_loader.sv - 8N1 serial deserializer feeding a downstream register
module serial_byte_loader
    import loader_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rxd,
    output logic [DATA_W-1:0] data_out,
    output logic              wen,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    logic rxd_s;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rxd),
        .q     (rxd_s)
    );

    // frame FSM: mid-bit sampling, LSB-first shift, stop-bit validation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        wen_d     = 1'b0;
        err_d     = err_q;
        if (!en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d = '0;
                        if (!rxd_s) begin
                            state_d   = ST_DATA;
                            bit_idx_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d     = '0;
                        shift_d   = {rxd_s, shift_q[DATA_W-1:1]};
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        if (rxd_s) begin
                            data_d  = shift_q;
                            wen_d   = 1'b1;
                            err_d   = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // a held-low break must release before a new start is accepted
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            wen_q     <= wen_d;
            err_q     <= err_d;
        end
    end

    assign data_out  = data_q;
    assign wen       = wen_q;
    assign frame_err = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
